// File: rtl/vram_pkg.sv
// Shared definitions for the screen-memory arbiter: RAM slot encoding and
// default bus widths.
package vram_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_PIX  = 2'd1,
    SLOT_ATTR = 2'd2,
    SLOT_CPU  = 2'd3
  } slot_t;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port screen RAM arbiter: video pixel/attribute bursts versus CPU
// accesses, one slot per clock, with a fairness credit for the CPU.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_fetch,
  input  logic [ADDR_W-1:0] vid_pix_addr,
  input  logic [ADDR_W-1:0] vid_attr_addr,
  output logic [DATA_W-1:0] vid_pix_data,
  output logic [DATA_W-1:0] vid_attr_data,
  output logic              vid_valid,
  output logic              vid_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  slot_t             r_slot;
  logic              r_vid_pend;
  logic              r_cpu_owed;
  logic [ADDR_W-1:0] r_pix_addr;
  logic [ADDR_W-1:0] r_attr_addr;
  logic [ADDR_W-1:0] r_burst_attr_addr;
  logic              r_rd_pix;
  logic              r_rd_attr;
  logic [DATA_W-1:0] r_pix_byte;
  logic [DATA_W-1:0] r_vid_pix_data;
  logic [DATA_W-1:0] r_vid_attr_data;
  logic              r_vid_valid;
  logic              r_vid_overrun;
  logic              r_cpu_ack;

  logic              w_cpu_req_eff;
  logic              w_vid_pend_eff;
  slot_t             w_slot_next;

  // A held request is not a new one while its slot or ack is in progress.
  assign w_cpu_req_eff  = cpu_req && !r_cpu_ack && (r_slot != SLOT_CPU);
  assign w_vid_pend_eff = r_vid_pend || vid_fetch;

  always_comb begin
    w_slot_next = SLOT_IDLE;
    if (r_slot == SLOT_PIX) begin
      w_slot_next = SLOT_ATTR;
    end else if (r_cpu_owed && w_cpu_req_eff) begin
      w_slot_next = SLOT_CPU;
    end else if (w_vid_pend_eff) begin
      w_slot_next = SLOT_PIX;
    end else if (w_cpu_req_eff) begin
      w_slot_next = SLOT_CPU;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (r_slot)
      SLOT_PIX:  mem_addr = r_pix_addr;
      SLOT_ATTR: mem_addr = r_burst_attr_addr;
      SLOT_CPU: begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
      end
      default: mem_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot            <= SLOT_IDLE;
      r_vid_pend        <= 1'b0;
      r_cpu_owed        <= 1'b0;
      r_pix_addr        <= '0;
      r_attr_addr       <= '0;
      r_burst_attr_addr <= '0;
      r_rd_pix          <= 1'b0;
      r_rd_attr         <= 1'b0;
      r_pix_byte        <= '0;
      r_vid_pix_data    <= '0;
      r_vid_attr_data   <= '0;
      r_vid_valid       <= 1'b0;
      r_vid_overrun     <= 1'b0;
      r_cpu_ack         <= 1'b0;
    end else begin
      r_slot <= w_slot_next;

      if (vid_fetch) begin
        r_pix_addr  <= vid_pix_addr;
        r_attr_addr <= vid_attr_addr;
        if (r_vid_pend) begin
          r_vid_overrun <= 1'b1;
        end
      end

      // The attribute address is frozen at PIX issue so a fetch arriving
      // mid-burst cannot redirect the ATTR half of the burst.
      if (w_slot_next == SLOT_PIX) begin
        r_vid_pend        <= 1'b0;
        r_burst_attr_addr <= vid_fetch ? vid_attr_addr : r_attr_addr;
      end else begin
        r_vid_pend <= w_vid_pend_eff;
      end

      if (w_slot_next == SLOT_CPU) begin
        r_cpu_owed <= 1'b0;
      end else if ((w_slot_next == SLOT_ATTR) && w_cpu_req_eff) begin
        r_cpu_owed <= 1'b1;
      end

      r_rd_pix  <= (r_slot == SLOT_PIX);
      r_rd_attr <= (r_slot == SLOT_ATTR);
      r_cpu_ack <= (r_slot == SLOT_CPU);

      if (r_rd_pix) begin
        r_pix_byte <= mem_rdata;
      end

      r_vid_valid <= r_rd_attr;
      if (r_rd_attr) begin
        r_vid_pix_data  <= r_pix_byte;
        r_vid_attr_data <= mem_rdata;
      end
    end
  end

  assign vid_pix_data  = r_vid_pix_data;
  assign vid_attr_data = r_vid_attr_data;
  assign vid_valid     = r_vid_valid;
  assign vid_overrun   = r_vid_overrun;
  assign cpu_ack       = r_cpu_ack;
  // RAM read data arrives in the ack cycle, so it is passed straight through.
  assign cpu_rdata     = r_cpu_ack ? mem_rdata : '0;
  assign cpu_wait      = cpu_req && !r_cpu_ack;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural RAM and expected-result
// queues drained when the arbiter reports video or CPU completions.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vid_fetch;
  logic [12:0] vid_pix_addr;
  logic [12:0] vid_attr_addr;
  logic [7:0]  vid_pix_data;
  logic [7:0]  vid_attr_data;
  logic        vid_valid;
  logic        vid_overrun;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_wait;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic       we;
    logic [7:0] d;
  } cpu_exp_t;

  logic [15:0] vid_q[$];
  cpu_exp_t    cpu_q[$];

  logic [7:0] ram [0:8191];
  bit         written [0:8191];

  vram_arbiter #(.ADDR_W(13), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .vid_fetch(vid_fetch), .vid_pix_addr(vid_pix_addr), .vid_attr_addr(vid_attr_addr),
    .vid_pix_data(vid_pix_data), .vid_attr_data(vid_attr_data),
    .vid_valid(vid_valid), .vid_overrun(vid_overrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [12:0] a);
    if (a == 13'h0000) return 8'hAA;
    if (a == 13'h1800) return 8'h47;
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ram_byte(input logic [12:0] a);
    return written[a] ? ram[a] : init_byte(a);
  endfunction

  // Synchronous single-port RAM: read data one cycle after the address.
  always @(posedge clk) begin
    mem_rdata <= ram_byte(mem_addr);
    if (mem_we) begin
      ram[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [15:0] ve;
    cpu_exp_t    ce;
    if (vid_valid) begin
      chk("vid_q_nonempty", 16'(vid_q.size() != 0), 16'd1);
      if (vid_q.size() != 0) begin
        ve = vid_q.pop_front();
        $display("vid txn pix=%02h attr=%02h", vid_pix_data, vid_attr_data);
        chk("vid_data", {vid_pix_data, vid_attr_data}, ve);
      end
    end
    if (cpu_ack) begin
      chk("cpu_q_nonempty", 16'(cpu_q.size() != 0), 16'd1);
      if (cpu_q.size() != 0) begin
        ce = cpu_q.pop_front();
        $display("cpu txn %s rdata=%02h", ce.we ? "write" : "read", cpu_rdata);
        if (!ce.we) chk("cpu_rdata", 16'(cpu_rdata), 16'(ce.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [12:0] pa, aa;
    reset = 1'b1; vid_fetch = 1'b0; vid_pix_addr = '0; vid_attr_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) tick();
    chk("rst_valid", 16'(vid_valid), 16'd0);
    chk("rst_ack", 16'(cpu_ack), 16'd0);
    chk("rst_overrun", 16'(vid_overrun), 16'd0);
    chk("rst_mem", {2'b00, mem_we, mem_addr}, 16'd0);
    chk("rst_vdata", {vid_pix_data, vid_attr_data}, 16'd0);
    reset = 1'b0;
    tick();

    // Idle-port video fetch
    vid_fetch = 1'b1; vid_pix_addr = 13'h0000; vid_attr_addr = 13'h1800;
    vid_q.push_back({8'hAA, 8'h47});
    tick(); vid_fetch = 1'b0;
    chk("v_pix_slot", {2'b00, mem_we, mem_addr}, 16'h0000);
    tick();
    chk("v_attr_slot", 16'(mem_addr), 16'h1800);
    tick();
    chk("v_valid_t3", 16'(vid_valid), 16'd0);
    tick();
    chk("v_valid_t4", 16'(vid_valid), 16'd1);
    chk("v_pix_t4", 16'(vid_pix_data), 16'h00AA);
    tick();
    chk("v_valid_t5", 16'(vid_valid), 16'd0);
    chk("v_hold", {vid_pix_data, vid_attr_data}, 16'hAA47);

    // CPU write then read-back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1800; cpu_wdata = 8'h38;
    cpu_q.push_back('{we: 1'b1, d: 8'h00});
    tick();
    chk("w_slot", {mem_we, mem_addr}, {1'b1, 13'h1800});
    chk("w_wdata", 16'(mem_wdata), 16'h0038);
    chk("w_ack_t1", 16'(cpu_ack), 16'd0);
    tick();
    chk("w_ack_t2", 16'(cpu_ack), 16'd1);
    chk("w_we_after", 16'(mem_we), 16'd0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_addr = 13'h1800;
    cpu_q.push_back('{we: 1'b0, d: 8'h38});
    tick();
    chk("r_slot", {mem_we, mem_addr}, {1'b0, 13'h1800});
    tick();
    chk("r_ack", 16'(cpu_ack), 16'd1);
    chk("r_rdata", 16'(cpu_rdata), 16'h0038);
    cpu_req = 1'b0;
    tick();

    // Simultaneous video fetch and CPU request: video wins
    vid_fetch = 1'b1; vid_pix_addr = 13'h0123; vid_attr_addr = 13'h1812;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0456;
    vid_q.push_back({ram_byte(13'h0123), ram_byte(13'h1812)});
    cpu_q.push_back('{we: 1'b0, d: ram_byte(13'h0456)});
    tick(); vid_fetch = 1'b0;
    chk("c_pix", 16'(mem_addr), 16'h0123);
    chk("c_wait1", 16'(cpu_wait), 16'd1);
    tick();
    chk("c_attr", 16'(mem_addr), 16'h1812);
    chk("c_wait2", 16'(cpu_wait), 16'd1);
    tick();
    chk("c_cpu", 16'(mem_addr), 16'h0456);
    chk("c_wait3", 16'(cpu_wait), 16'd1);
    chk("c_noack", 16'(cpu_ack), 16'd0);
    tick();
    chk("c_ack", 16'(cpu_ack), 16'd1);
    chk("c_wait_off", 16'(cpu_wait), 16'd0);
    chk("c_vvalid", 16'(vid_valid), 16'd1);
    cpu_req = 1'b0;
    repeat (2) tick();

    // Fetch every 3 cycles with CPU request held: PIX, ATTR, CPU repeating
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0777;
    for (int k = 0; k < 4; k++) begin
      pa = 13'h0200 + 13'(k * 33);
      aa = 13'h1900 + 13'(k);
      vid_fetch = 1'b1; vid_pix_addr = pa; vid_attr_addr = aa;
      vid_q.push_back({ram_byte(pa), ram_byte(aa)});
      tick(); vid_fetch = 1'b0;
      chk("h_pix", 16'(mem_addr), 16'(pa));
      chk("h_overrun", 16'(vid_overrun), 16'd0);
      tick();
      chk("h_attr", 16'(mem_addr), 16'(aa));
      tick();
      chk("h_cpu", {mem_we, mem_addr}, {1'b0, 13'h0777});
      cpu_q.push_back('{we: 1'b0, d: ram_byte(13'h0777)});
    end
    cpu_req = 1'b0;
    tick();
    chk("h_overrun_end", 16'(vid_overrun), 16'd0);
    repeat (3) tick();

    // Overrun: second fetch lands while the owed CPU slot is active
    vid_fetch = 1'b1; vid_pix_addr = 13'h0300; vid_attr_addr = 13'h1A00;
    cpu_req = 1'b1; cpu_addr = 13'h0888;
    vid_q.push_back({ram_byte(13'h0300), ram_byte(13'h1A00)});
    cpu_q.push_back('{we: 1'b0, d: ram_byte(13'h0888)});
    tick(); vid_fetch = 1'b0;
    chk("o_pix0", 16'(mem_addr), 16'h0300);
    tick();
    chk("o_attr0", 16'(mem_addr), 16'h1A00);
    vid_fetch = 1'b1; vid_pix_addr = 13'h0311; vid_attr_addr = 13'h1A11;
    tick();
    chk("o_cpu", 16'(mem_addr), 16'h0888);
    chk("o_ovr_before", 16'(vid_overrun), 16'd0);
    vid_fetch = 1'b1; vid_pix_addr = 13'h0322; vid_attr_addr = 13'h1A22;
    vid_q.push_back({ram_byte(13'h0322), ram_byte(13'h1A22)});
    tick(); vid_fetch = 1'b0;
    chk("o_ovr_set", 16'(vid_overrun), 16'd1);
    chk("o_pix2", 16'(mem_addr), 16'h0322);
    chk("o_ack", 16'(cpu_ack), 16'd1);
    cpu_req = 1'b0;
    tick();
    chk("o_attr2", 16'(mem_addr), 16'h1A22);
    repeat (3) tick();
    chk("o_ovr_sticky", 16'(vid_overrun), 16'd1);

    // Reset during ATTR abandons the burst
    vid_fetch = 1'b1; vid_pix_addr = 13'h0404; vid_attr_addr = 13'h1A44;
    vid_q.push_back({ram_byte(13'h0404), ram_byte(13'h1A44)});
    tick(); vid_fetch = 1'b0;
    chk("x_pix", 16'(mem_addr), 16'h0404);
    tick();
    chk("x_attr", 16'(mem_addr), 16'h1A44);
    reset = 1'b1;
    vid_q.delete();
    tick();
    chk("x_valid", 16'(vid_valid), 16'd0);
    chk("x_mem", {2'b00, mem_we, mem_addr}, 16'd0);
    chk("x_ack", 16'(cpu_ack), 16'd0);
    chk("x_overrun", 16'(vid_overrun), 16'd0);
    chk("x_vdata", {vid_pix_data, vid_attr_data}, 16'd0);
    reset = 1'b0;
    tick();
    chk("x_valid_late", 16'(vid_valid), 16'd0);
    vid_fetch = 1'b1; vid_pix_addr = 13'h0505; vid_attr_addr = 13'h1A55;
    vid_q.push_back({ram_byte(13'h0505), ram_byte(13'h1A55)});
    tick(); vid_fetch = 1'b0;
    repeat (3) tick();
    chk("x_refetch_valid", 16'(vid_valid), 16'd1);
    repeat (2) tick();

    chk("vid_q_drained", 16'(vid_q.size()), 16'd0);
    chk("cpu_q_drained", 16'(cpu_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
